// File: rtl/network_div_30s_14ns_16_seq_if.sv
// Operand/result handshake bundle for the sequential requantization divider.
// The producer/consumer side uses master; the divider uses slave.
interface network_div_30s_14ns_16_seq_if #(
    parameter int DIVIDEND_WIDTH = 30,
    parameter int DIVISOR_WIDTH  = 14,
    parameter int QUOTIENT_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [QUOTIENT_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      overflow;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/network_div_30s_14ns_16_seq.sv
// Restoring divider: signed 30-bit accumulator / unsigned 14-bit scale -> saturated
// signed 16-bit quotient, one bit per cycle, one operation in flight.
module network_div_30s_14ns_16_seq #(
    parameter int DIVIDEND_WIDTH = 30,
    parameter int DIVISOR_WIDTH  = 14,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    network_div_30s_14ns_16_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);
    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = DIVIDEND_WIDTH'((2 ** (QUOTIENT_WIDTH - 1)) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = DIVIDEND_WIDTH'(2 ** (QUOTIENT_WIDTH - 1));
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH - 1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state_q, state_d;

    logic                      sign_q;
    logic [DIVIDEND_WIDTH-1:0] mag_q;
    logic [DIVISOR_WIDTH-1:0]  div_q;
    logic [DIVISOR_WIDTH:0]    rem_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [QUOTIENT_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  remainder_q;
    logic                      overflow_q;
    logic                      div_by_zero_q;
    logic                      out_valid_q;

    logic                      accept;
    logic [DIVIDEND_WIDTH-1:0] in_mag;
    logic [DIVISOR_WIDTH:0]    r_shift;
    logic                      r_ge;
    logic [DIVISOR_WIDTH:0]    r_next;
    logic [QUOTIENT_WIDTH-1:0] quo_low;
    logic [QUOTIENT_WIDTH-1:0] fix_q;
    logic                      fix_ovf;

    assign accept = bus.in_valid && (state_q == IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        in_mag  = bus.dividend[DIVIDEND_WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        r_shift = {rem_q[DIVISOR_WIDTH-1:0], mag_q[DIVIDEND_WIDTH-1]};
        r_ge    = (r_shift >= {1'b0, div_q});
        r_next  = r_ge ? (r_shift - {1'b0, div_q}) : r_shift;
        quo_low = quo_q[QUOTIENT_WIDTH-1:0];
        fix_q   = quo_low;
        fix_ovf = 1'b0;

        // Negative results may reach one step further than positive ones (-2^15).
        if (!sign_q) begin
            if (quo_q > POS_LIMIT) begin
                fix_q   = Q_MAX;
                fix_ovf = 1'b1;
            end
        end else if (quo_q > NEG_LIMIT) begin
            fix_q   = Q_MIN;
            fix_ovf = 1'b1;
        end else begin
            fix_q = ~quo_low + 1'b1;
        end

        case (state_q)
            IDLE: if (accept) state_d = (bus.divisor == '0) ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q        <= 1'b0;
            mag_q         <= '0;
            div_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sign_q        <= bus.dividend[DIVIDEND_WIDTH-1];
                        mag_q         <= in_mag;
                        div_q         <= bus.divisor;
                        rem_q         <= '0;
                        quo_q         <= '0;
                        cnt_q         <= CNT_W'(DIVIDEND_WIDTH);
                        overflow_q    <= 1'b0;
                        div_by_zero_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_q    <= bus.dividend[DIVIDEND_WIDTH-1] ? Q_MIN : Q_MAX;
                            remainder_q   <= '0;
                            div_by_zero_q <= 1'b1;
                            out_valid_q   <= 1'b1;
                            cnt_q         <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= r_next;
                    quo_q <= {quo_q[DIVIDEND_WIDTH-2:0], r_ge};
                    mag_q <= {mag_q[DIVIDEND_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    quotient_q  <= fix_q;
                    remainder_q <= rem_q[DIVISOR_WIDTH-1:0];
                    overflow_q  <= fix_ovf;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_network_div_30s_14ns_16_seq.sv
// Scoreboard bench for the sequential divider: expected results are queued on
// drive and compared when out_valid rises; covers saturation, /0, backpressure, reset.
module tb_network_div_30s_14ns_16_seq;
    localparam int DW  = 30;
    localparam int DSW = 14;
    localparam int QW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    network_div_30s_14ns_16_seq_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DSW), .QUOTIENT_WIDTH(QW)) ifc ();

    network_div_30s_14ns_16_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DSW), .QUOTIENT_WIDTH(QW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        longint q;
        longint r;
        bit     ovf;
        bit     dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input longint a, input longint d);
        exp_t   e;
        longint mag;
        longint qs;
        mag   = (a < 0) ? -a : a;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        if (d == 0) begin
            e.q   = (a >= 0) ? 32767 : -32768;
            e.r   = 0;
            e.dbz = 1'b1;
        end else begin
            e.r = mag % d;
            qs  = (a < 0) ? -(mag / d) : (mag / d);
            if (qs > 32767) begin
                e.q   = 32767;
                e.ovf = 1'b1;
            end else if (qs < -32768) begin
                e.q   = -32768;
                e.ovf = 1'b1;
            end else begin
                e.q = qs;
            end
        end
        return e;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!ifc.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_accept", longint'(ifc.in_ready), 1);
    endtask

    task automatic run_op(input longint a, input longint d, input int bp_cycles);
        exp_t e;
        int   lat;
        bit   busy_ok;
        bit   stable_ok;
        bit   hold_ready_ok;
        logic [QW+DSW+2:0] snap;

        wait_ready();
        ifc.dividend  = DW'(a);
        ifc.divisor   = DSW'(d);
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b0;
        sb.push_back(model(a, d));
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;

        lat     = 0;
        busy_ok = 1'b1;
        while (!ifc.out_valid && lat < 60) begin
            if (ifc.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (ifc.in_ready) busy_ok = 1'b0;
        check("latency", lat, (d == 0) ? 0 : 31);
        check("in_ready_low_busy", longint'(busy_ok), 1);

        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("quotient", longint'($signed(ifc.quotient)), e.q);
            check("remainder", longint'(ifc.remainder), e.r);
            check("overflow", longint'(ifc.overflow), longint'(e.ovf));
            check("div_by_zero", longint'(ifc.div_by_zero), longint'(e.dbz));
        end

        if (bp_cycles > 0) begin
            snap          = {ifc.out_valid, ifc.overflow, ifc.div_by_zero, ifc.quotient, ifc.remainder};
            stable_ok     = 1'b1;
            hold_ready_ok = 1'b1;
            for (int i = 0; i < bp_cycles; i++) begin
                ifc.in_valid = ~ifc.in_valid;
                ifc.dividend = DW'($urandom);
                ifc.divisor  = DSW'($urandom);
                @(posedge clk); #1;
                if ({ifc.out_valid, ifc.overflow, ifc.div_by_zero, ifc.quotient, ifc.remainder} !== snap)
                    stable_ok = 1'b0;
                if (ifc.in_ready !== 1'b0) hold_ready_ok = 1'b0;
            end
            ifc.in_valid = 1'b0;
            check("backpressure_outputs_stable", longint'(stable_ok), 1);
            check("backpressure_in_ready_low", longint'(hold_ready_ok), 1);
        end

        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        check("out_valid_after_handshake", longint'(ifc.out_valid), 0);
        check("in_ready_after_handshake", longint'(ifc.in_ready), 1);
    endtask

    task automatic reset_mid_calc();
        bit stale_ok;
        wait_ready();
        ifc.dividend = DW'(1000);
        ifc.divisor  = DSW'(7);
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid_low", longint'(ifc.out_valid), 0);
        #9;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready_after_release", longint'(ifc.in_ready), 1);
        check("reset_quotient_cleared", longint'(ifc.quotient), 0);
        stale_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid !== 1'b0) stale_ok = 1'b0;
        end
        check("no_stale_result", longint'(stale_ok), 1);
    endtask

    initial begin
        logic signed [DW-1:0] rnd_a;
        ifc.in_valid  = 1'b0;
        ifc.dividend  = '0;
        ifc.divisor   = '0;
        ifc.out_ready = 1'b0;

        #3;
        check("rst_out_valid", longint'(ifc.out_valid), 0);
        check("rst_in_ready", longint'(ifc.in_ready), 1);
        check("rst_quotient", longint'(ifc.quotient), 0);
        check("rst_remainder", longint'(ifc.remainder), 0);
        check("rst_overflow", longint'(ifc.overflow), 0);
        check("rst_div_by_zero", longint'(ifc.div_by_zero), 0);
        #19;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1000, 7, 0);
        run_op(-1000, 7, 10);
        run_op(-6, 7, 0);
        run_op(536870911, 1, 0);
        run_op(-32768, 1, 0);
        run_op(-32769, 1, 0);
        run_op(-536870912, 16383, 0);
        run_op(-5, 0, 0);
        run_op(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rnd_a = DW'($urandom);
            run_op(longint'(rnd_a), longint'($urandom_range(1, 16383)), 0);
        end

        reset_mid_calc();
        run_op(100, 3, 0);

        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
